// File: rtl/sw_pkg.sv
// Shared definitions for the switch conditioner: FSM encoding and 50 MHz default timing.
package sw_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } sw_state_e;

    localparam int DEB_CYCLES_DEF  = 1_000_000;   // 20 ms at 50 MHz
    localparam int LONG_CYCLES_DEF = 50_000_000;  // 1 s at 50 MHz

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch-side bundle: raw switch in, conditioned level/strobes/count out.
interface sw_debounce_if;
    logic       iSW;
    logic       oSW_STABLE;
    logic       oRISE;
    logic       oFALL;
    logic [7:0] oCNT;
    logic       oLONG;

    modport master (output iSW, input oSW_STABLE, oRISE, oFALL, oCNT, oLONG);
    modport slave  (input iSW, output oSW_STABLE, oRISE, oFALL, oCNT, oLONG);
endinterface

// File: rtl/sw_debounce_sync2.sv
// Generic two-flop synchroniser with synchronous reset to 0, for any asynchronous input.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;
endmodule

// File: rtl/sw_debounce.sv
// Debounced switch: level, edge strobes, press counter and optional long-press strobe.
// Long-press detection is built only when SW_DEBOUNCE_LONGPRESS_EN is defined.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic          iCLK,
    input  logic          iRST,
    sw_debounce_if.slave  sw_bus
);
    localparam int CNT_W = $clog2(max_int(DEB_CYCLES, LONG_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic            sw_sync;
    sw_state_e       state_q, state_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic            accept_hi, accept_lo;
    logic            stable_q, stable_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic [7:0]      press_cnt_q, press_cnt_d;

    sync2 #(.WIDTH(1)) u_sync2 (
        .clk  (iCLK),
        .srst (iRST),
        .d    (sw_bus.iSW),
        .q    (sw_sync)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= IDLE_LO;
            deb_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Counter holds at DEB_LAST on acceptance, so it can never wrap.
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        case (state_q)
            IDLE_LO: if (sw_sync) begin
                state_d   = WAIT_HI;
                deb_cnt_d = '0;
            end
            WAIT_HI: begin
                if (!sw_sync)                  state_d   = IDLE_LO;
                else if (deb_cnt_q == DEB_LAST) state_d   = IDLE_HI;
                else                           deb_cnt_d = deb_cnt_q + CNT_W'(1);
            end
            IDLE_HI: if (!sw_sync) begin
                state_d   = WAIT_LO;
                deb_cnt_d = '0;
            end
            WAIT_LO: begin
                if (sw_sync)                   state_d   = IDLE_HI;
                else if (deb_cnt_q == DEB_LAST) state_d   = IDLE_LO;
                else                           deb_cnt_d = deb_cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE_LO;
        endcase
    end

    always_comb begin
        accept_hi   = (state_q == WAIT_HI) &&  sw_sync && (deb_cnt_q == DEB_LAST);
        accept_lo   = (state_q == WAIT_LO) && !sw_sync && (deb_cnt_q == DEB_LAST);
        stable_d    = stable_q;
        if (accept_hi) stable_d = 1'b1;
        if (accept_lo) stable_d = 1'b0;
        rise_d      = accept_hi;
        fall_d      = accept_lo;
        press_cnt_d = press_cnt_q + {7'd0, accept_hi};
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            stable_q    <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            press_cnt_q <= 8'd0;
        end else begin
            stable_q    <= stable_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign sw_bus.oSW_STABLE = stable_q;
    assign sw_bus.oRISE      = rise_q;
    assign sw_bus.oFALL      = fall_q;
    assign sw_bus.oCNT       = press_cnt_q;

`ifdef SW_DEBOUNCE_LONGPRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    logic [CNT_W-1:0] long_cnt_q, long_cnt_d;
    logic             long_q, long_d;

    // Strobe fires on the step into LONG_LAST; saturating there gives one pulse per press.
    always_comb begin
        long_cnt_d = '0;
        long_d     = 1'b0;
        if (state_q == IDLE_HI) begin
            if (long_cnt_q != LONG_LAST) begin
                long_cnt_d = long_cnt_q + CNT_W'(1);
                long_d     = (long_cnt_d == LONG_LAST);
            end else begin
                long_cnt_d = long_cnt_q;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            long_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            long_cnt_q <= long_cnt_d;
            long_q     <= long_d;
        end
    end

    assign sw_bus.oLONG = long_q;
`else
    assign sw_bus.oLONG = 1'b0;
`endif

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input-side conditioner for board slide switches and push-buttons: synchronises a raw mechanical switch into the iCLK domain, debounces it, and emits a clean level, single-cycle edge strobes and an 8-bit press counter. It is the input counterpart of the LED pattern drivers, and feeds them a clean control signal in place of raw iSW. One instance per physical switch.

## Interface
- DEB_CYCLES, 1_000_000: consecutive stable samples required to accept a new level (20 ms at 50 MHz); minimum 2.
- LONG_CYCLES, 50_000_000: cycles the debounced level must stay high to flag a long press (1 s at 50 MHz); used only with the long-press feature.
- iCLK  in  1  system clock, 50 MHz.
- iRST  in  1  synchronous, active-high reset.
- iSW  in  1  raw asynchronous switch input.
- oSW_STABLE  out  1  debounced switch level.
- oRISE  out  1  one-cycle strobe on a debounced 0->1 transition.
- oFALL  out  1  one-cycle strobe on a debounced 1->0 transition.
- oCNT  out  8  count of debounced rising edges, modulo 256.
- oLONG  out  1  one-cycle long-press strobe. Tied 0 when the feature is compiled out.

## Operation
- Reset values: all outputs 0. The FSM enters IDLE_LO. Both synchroniser flops, the debounce counter and the long counter are 0.
- Two-flop synchroniser: iSW -> s1 -> s2. The FSM sees only s2.
- FSM states and transitions:
  - IDLE_LO: if s2=1, go to WAIT_HI and clear the counter.
  - WAIT_HI:
    - If s2=0, return to IDLE_LO.
    - Else the counter increments.
    - When the counter reaches DEB_CYCLES-1 with s2=1, go to IDLE_HI, set oSW_STABLE=1, pulse oRISE and increment oCNT.
  - IDLE_HI: if s2=0, go to WAIT_LO and clear the counter.
  - WAIT_LO: mirror of WAIT_HI. On acceptance, go to IDLE_LO, set oSW_STABLE=0 and pulse oFALL.
- A glitch shorter than DEB_CYCLES samples produces no output change. The counter restarts on every bounce.
- oCNT wraps from 255 to 0 with no flag.
- The counter width is clog2(max(DEB_CYCLES, LONG_CYCLES))+1 bits. It never overflows because it saturates at its terminal value.
- Reset mid-WAIT abandons the pending transition. If iSW is still high after reset, a full debounce follows and oRISE fires normally.
- oRISE and oFALL are never asserted in the same cycle.

## Timing
- All outputs are registered.
- A clean iSW step is reflected on oSW_STABLE and on the strobe exactly DEB_CYCLES+2 rising edges after the first edge that samples the new level:
  - 2 edges for synchronisation.
  - DEB_CYCLES edges for the debounce count.
- oRISE, oFALL and oLONG are high for exactly one cycle.
- oCNT updates in the same cycle as oRISE.
- iRST dominates every other input in the cycle it is high.

## Configuration
- SW_DEBOUNCE_LONGPRESS_EN defined:
  - A second counter runs while the FSM is in IDLE_HI.
  - When it reaches LONG_CYCLES-1, oLONG pulses once and the counter saturates, so there is one pulse per press.
  - Leaving IDLE_HI clears the counter.
- SW_DEBOUNCE_LONGPRESS_EN undefined: no long counter is built and oLONG is constant 0. The port list is unchanged.

## Structure
- Shared package sw_pkg holds:
  - the FSM state encoding (IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO), 2 bits;
  - the default cycle constants for 50 MHz.
- One sub-module, sync2: a generic two-flop synchroniser with synchronous reset to 0. The team's other asynchronous inputs reuse it.
- The FSM, counters and output registers are in the top module.

## Test plan
Bench settings: DEB_CYCLES=4, LONG_CYCLES=16, 20 ns clock.
- Reset then clean rise: iSW 0->1 and held -> oSW_STABLE=1 and a single oRISE exactly 6 edges later; oCNT=1.
- Bounce: iSW toggles 1,0,1,0 each 2 cycles, then holds 1 -> no strobe until 6 edges after the final rise; exactly one oRISE.
- Short glitch: iSW high for 3 cycles, then low -> oSW_STABLE stays 0; no oRISE or oFALL.
- Wrap: 256 clean press/release cycles -> oCNT goes 255->0 and 256 oRISE and 256 oFALL are counted.
- Reset mid-debounce: iRST asserted during WAIT_HI with iSW held high -> all outputs 0; after release, oRISE 6 edges later.
- Long press (with the macro defined): hold iSW high for 40 cycles -> exactly one oLONG, 15 edges after oRISE. With the macro undefined, oLONG stays 0.
